events_to_apb_mc: RTL and testbench

- Multi-channel successor to the single-event APB bridge.
- Counts event pulses on NUM_CH independent channels and arbitrates round-robin among channels with pending events.
- Issues one APB write per grant carrying the accumulated count and an overflow flag to a per-channel address.
- Sits between peripheral event sources and the APB interconnect as an APB requester (master).

---
 rtl/events_to_apb_mc.sv | 151 +++++++++++++++
 tb/tb_events_to_apb_mc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/events_to_apb_mc.sv
// Multi-channel event counter with an APB write requester.
// Each channel accumulates event pulses in a saturating counter. A
// round-robin arbiter picks one non-empty channel at a time. The bridge then
// writes that channel's count and overflow flag to the channel's APB record.
module events_to_apb_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          event_i,
  input  logic                       enable_i,
  output logic [ADDR_W-1:0]          paddr_o,
  output logic                       psel_o,
  output logic                       penable_o,
  output logic                       pwrite_o,
  output logic [DATA_W-1:0]          pwdata_o,
  input  logic                       pready_i,
  input  logic                       pslverr_i,
  output logic [NUM_CH-1:0]          pend_o,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [$clog2(NUM_CH)-1:0]  err_ch_o
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam logic [CH_W:0] NUM_CH_EXT = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   cur_ch;

  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W:0]     cand;
  logic              grant_fire;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  // Round-robin search: the lowest offset from ptr with a non-zero count wins.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (CH_W+1)'(i);
      if (cand >= NUM_CH_EXT) cand = cand - NUM_CH_EXT;
      if (cnt[cand[CH_W-1:0]] != '0) begin
        grant_valid = 1'b1;
        grant_ch    = cand[CH_W-1:0];
      end
    end
  end

  // Build the APB record for the candidate channel (address wraps at ADDR_W).
  always_comb begin
    grant_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(grant_ch) * ADDR_W'(ADDR_STRIDE);
    grant_data = '0;
    grant_data[CNT_W-1:0] = cnt[grant_ch];
    grant_data[DATA_W-1]  = ovf[grant_ch];
  end

  assign grant_fire = (state == IDLE) && enable_i && grant_valid;
  assign busy_o     = (state != IDLE);

  // A channel is pending whenever its counter is non-zero.
  always_comb begin
    pend_o = '0;
    for (int c = 0; c < NUM_CH; c++) pend_o[c] = |cnt[c];
  end

  // Per-channel saturating counters. The granted channel is cleared on the
  // grant edge, but an event arriving on that same edge is kept as a count of 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the counters are architectural state, so the whole array is reset here rather than left uninitialised like a RAM.
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      ovf <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (grant_fire && (CH_W'(c) == grant_ch)) begin
          cnt[c] <= event_i[c] ? CNT_W'(1) : '0;
          ovf[c] <= 1'b0;
        end else if (event_i[c]) begin
          if (&cnt[c]) ovf[c] <= 1'b1;
          else         cnt[c] <= cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  // APB transfer FSM with registered bus outputs and error reporting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_ch    <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      err_o     <= 1'b0;
      err_ch_o  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            state    <= SETUP;
            psel_o   <= 1'b1;
            pwrite_o <= 1'b1;
            paddr_o  <= grant_addr;
            pwdata_o <= grant_data;
            cur_ch   <= grant_ch;
            ptr      <= (grant_ch == LAST_CH) ? '0 : grant_ch + CH_W'(1);
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (pready_i) begin
            state     <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            if (pslverr_i) begin
              err_o    <= 1'b1;
              err_ch_o <= cur_ch;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_events_to_apb_mc.sv
// Directed bench for events_to_apb_mc. Each expected APB write is queued when
// its events are driven. A monitor pops and compares each entry as the
// transfer completes.
module tb_events_to_apb_mc;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] event_i;
  logic              enable_i;
  logic [ADDR_W-1:0] paddr_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pready_i;
  logic              pslverr_i;
  logic [NUM_CH-1:0] pend_o;
  logic              busy_o;
  logic              err_o;
  logic [1:0]        err_ch_o;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } xfer_t;

  xfer_t sb[$];
  xfer_t mon_exp;
  int    checks   = 0;
  int    errors   = 0;
  int    done_cnt = 0;

  events_to_apb_mc #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BASE_ADDR(32'h100), .ADDR_STRIDE(4)
  ) dut (
    .clk(clk), .reset(rst_n), .event_i(event_i), .enable_i(enable_i),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .pend_o(pend_o), .busy_o(busy_o),
    .err_o(err_o), .err_ch_o(err_ch_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [DATA_W-1:0] data);
    xfer_t e;
    e.addr = 16'h100 + ADDR_W'(ch * 4);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < budget) begin
      step();
      n++;
    end
    chk("drain_queue_empty", 64'(sb.size()), 64'(0));
    chk("drain_idle", 64'(busy_o), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Completing transfer: compare against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && psel_o && penable_o && pready_i) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("xfer_addr", 64'(paddr_o), 64'(mon_exp.addr));
        chk("xfer_data", 64'(pwdata_o), 64'(mon_exp.data));
        chk("xfer_pwrite", 64'(pwrite_o), 64'(1));
      end
      done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    event_i   = '0;
    enable_i  = 1'b1;
    pready_i  = 1'b1;
    pslverr_i = 1'b0;

    // Reset state
    #12;
    chk("rst_psel", 64'(psel_o), 64'(0));
    chk("rst_penable", 64'(penable_o), 64'(0));
    chk("rst_pwrite", 64'(pwrite_o), 64'(0));
    chk("rst_paddr", 64'(paddr_o), 64'(0));
    chk("rst_pwdata", 64'(pwdata_o), 64'(0));
    chk("rst_pend", 64'(pend_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_err_ch", 64'(err_ch_o), 64'(0));
    step();
    rst_n = 1'b1;
    step();

    // Single pulse on ch2: latency and bus phases
    push(2, 32'h1);
    event_i = 4'b0100;
    step();
    event_i = '0;
    chk("t1_pend", 64'(pend_o), 64'(4'b0100));
    chk("t1_psel_not_yet", 64'(psel_o), 64'(0));
    step();
    chk("t1_setup_psel", 64'(psel_o), 64'(1));
    chk("t1_setup_penable", 64'(penable_o), 64'(0));
    chk("t1_setup_pwrite", 64'(pwrite_o), 64'(1));
    chk("t1_setup_paddr", 64'(paddr_o), 64'(16'h108));
    chk("t1_setup_pwdata", 64'(pwdata_o), 64'(32'h1));
    chk("t1_setup_pend", 64'(pend_o), 64'(0));
    chk("t1_setup_busy", 64'(busy_o), 64'(1));
    step();
    chk("t1_access_penable", 64'(penable_o), 64'(1));
    chk("t1_access_psel", 64'(psel_o), 64'(1));
    step();
    chk("t1_done_psel", 64'(psel_o), 64'(0));
    chk("t1_done_busy", 64'(busy_o), 64'(0));
    chk("t1_done_pend", 64'(pend_o), 64'(0));
    chk("t1_hold_paddr", 64'(paddr_o), 64'(16'h108));

    // All four channels from a fresh pointer, then ch0/ch3
    do_reset();
    for (int c = 0; c < NUM_CH; c++) push(c, 32'h1);
    event_i = 4'b1111;
    step();
    event_i = '0;
    chk("t2_pend_all", 64'(pend_o), 64'(4'b1111));
    drain(40);
    push(0, 32'h1);
    push(3, 32'h1);
    event_i = 4'b1001;
    step();
    event_i = '0;
    drain(20);

    // Stall on ch0 while ch1 saturates
    pready_i = 1'b0;
    push(0, 32'h1);
    event_i = 4'b0001;
    step();
    event_i = '0;
    for (int i = 0; i < 10 && !penable_o; i++) step();
    chk("t3_in_access", 64'(penable_o), 64'(1));
    event_i = 4'b0010;
    repeat (300) step();
    event_i = '0;
    chk("t3_still_stalled", 64'(psel_o && penable_o), 64'(1));
    chk("t3_paddr_held", 64'(paddr_o), 64'(16'h100));
    chk("t3_pend_ch1", 64'(pend_o), 64'(4'b0010));
    push(1, 32'h8000_00FF);
    pready_i = 1'b1;
    drain(20);
    push(1, 32'h1);
    event_i = 4'b0010;
    step();
    event_i = '0;
    drain(20);

    // Event on the grant edge of ch1 with count 3
    enable_i = 1'b0;
    event_i  = 4'b0010;
    repeat (3) step();
    chk("t4_no_grant_disabled", 64'(busy_o), 64'(0));
    chk("t4_pend_disabled", 64'(pend_o), 64'(4'b0010));
    enable_i = 1'b1;
    step();
    event_i = '0;
    chk("t4_grant_psel", 64'(psel_o), 64'(1));
    chk("t4_grant_data", 64'(pwdata_o), 64'(32'h3));
    chk("t4_pend_kept", 64'(pend_o[1]), 64'(1));
    push(1, 32'h3);
    push(1, 32'h1);
    drain(30);

    // Slave error on ch3, then a normal transfer
    pslverr_i = 1'b1;
    push(3, 32'h1);
    event_i = 4'b1000;
    step();
    event_i = '0;
    step();
    step();
    chk("t5_err_before", 64'(err_o), 64'(0));
    step();
    chk("t5_err_pulse", 64'(err_o), 64'(1));
    chk("t5_err_ch", 64'(err_ch_o), 64'(3));
    pslverr_i = 1'b0;
    step();
    chk("t5_err_one_cycle", 64'(err_o), 64'(0));
    chk("t5_err_ch_held", 64'(err_ch_o), 64'(3));
    push(0, 32'h1);
    event_i = 4'b0001;
    step();
    event_i = '0;
    drain(20);
    chk("t5_no_err_after", 64'(err_o), 64'(0));

    // Reset in ACCESS with cnt[0]=5
    pready_i = 1'b0;
    event_i  = 4'b0010;
    step();
    event_i = '0;
    step();
    step();
    event_i = 4'b0001;
    repeat (5) step();
    event_i = '0;
    chk("t6_in_access", 64'(penable_o), 64'(1));
    chk("t6_pend_ch0", 64'(pend_o), 64'(4'b0001));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_psel", 64'(psel_o), 64'(0));
    chk("t6_rst_penable", 64'(penable_o), 64'(0));
    chk("t6_rst_pend", 64'(pend_o), 64'(0));
    step();
    rst_n    = 1'b1;
    pready_i = 1'b1;
    repeat (10) step();
    chk("t6_no_replay_busy", 64'(busy_o), 64'(0));
    chk("t6_no_replay_pend", 64'(pend_o), 64'(0));
    push(2, 32'h1);
    event_i = 4'b0100;
    step();
    event_i = '0;
    drain(20);

    chk("xfer_total", 64'(done_cnt), 64'(15));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
